ipr_responder: RTL and testbench

Target-side endpoint of the inter-processor-region (IPR) links. It accepts read/write requests arriving from the four neighbour tiles (N, S, E, W) plus the local core, and arbitrates them round-robin onto a single flop-based mailbox. It returns one-cycle-latency responses on the requesting lane. Remote writes set per-word valid flags that raise an interrupt to the local core; local reads consume them.

---
 rtl/ipr_responder.sv | 171 +++++++++++++++++
 tb/tb_ipr_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipr_responder.sv
// IPR target endpoint: round-robin arbitration of four remote lanes plus the local
// core onto a flop-based mailbox, with one-cycle responses and remote-write flags.
module ipr_responder #(
    parameter  int MBOX_WORDS = 16,
    localparam int IDXW       = $clog2(MBOX_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            rmt_req_i,
    input  logic [3:0]            rmt_we_i,
    input  logic [127:0]          rmt_addr_i,
    input  logic [127:0]          rmt_wdata_i,
    input  logic [15:0]           rmt_be_i,
    output logic [3:0]            rmt_gnt_o,
    output logic [3:0]            rmt_rvalid_o,
    output logic [127:0]          rmt_rdata_o,
    input  logic                  loc_req_i,
    input  logic                  loc_we_i,
    input  logic [31:0]           loc_addr_i,
    input  logic [31:0]           loc_wdata_i,
    input  logic [3:0]            loc_be_i,
    output logic                  loc_gnt_o,
    output logic                  loc_rvalid_o,
    output logic [31:0]           loc_rdata_o,
    output logic [MBOX_WORDS-1:0] mbox_valid_o,
    output logic                  mbox_irq_o
);

    localparam int          NSRC    = 5;
    localparam logic [2:0]  LOC_SRC = 3'd4;

    logic [4:0]      req_all;
    logic [31:0]     src_addr  [NSRC];
    logic [31:0]     src_wdata [NSRC];
    logic [3:0]      src_be    [NSRC];
    logic [NSRC-1:0] src_we;

    logic            gnt_any;
    logic [2:0]      gnt_src;
    logic [3:0]      cand_sum;
    logic [4:0]      gnt_vec;

    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [3:0]      sel_be;
    logic            sel_we;
    logic [IDXW-1:0] sel_idx;
    logic            unused_addr_bits;

    logic [2:0]            rr_ptr_q, rr_ptr_d;
    logic [31:0]           mbox_q [MBOX_WORDS];
    logic [MBOX_WORDS-1:0] mbox_valid_q, mbox_valid_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [2:0]            resp_src_q, resp_src_d;
    logic                  resp_we_q, resp_we_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;

    assign req_all = {loc_req_i, rmt_req_i};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            src_addr[k]  = rmt_addr_i[32*k +: 32];
            src_wdata[k] = rmt_wdata_i[32*k +: 32];
            src_be[k]    = rmt_be_i[4*k +: 4];
            src_we[k]    = rmt_we_i[k];
        end
        src_addr[4]  = loc_addr_i;
        src_wdata[4] = loc_wdata_i;
        src_be[4]    = loc_be_i;
        src_we[4]    = loc_we_i;
    end

    // Search starts one past the last winner and wraps modulo the five sources.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt_any  = 1'b0;
        gnt_src  = rr_ptr_q;
        cand_sum = '0;
        for (int i = 1; i <= NSRC; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + 4'(i);
            if (cand_sum >= 4'(NSRC)) begin
                cand_sum = cand_sum - 4'(NSRC);
            end
            if (!gnt_any && req_all[cand_sum[2:0]]) begin
                gnt_any = 1'b1;
                gnt_src = cand_sum[2:0];
            end
        end
    end

    assign gnt_vec   = gnt_any ? (5'b00001 << gnt_src) : 5'b00000;
    assign rmt_gnt_o = gnt_vec[3:0];
    assign loc_gnt_o = gnt_vec[4];

    assign sel_addr  = src_addr[gnt_src];
    assign sel_wdata = src_wdata[gnt_src];
    assign sel_be    = src_be[gnt_src];
    assign sel_we    = src_we[gnt_src];
    assign sel_idx   = sel_addr[IDXW+1:2];

    // Upper address bits and the byte offset wrap by design.
    assign unused_addr_bits = ^{sel_addr[31:IDXW+2], sel_addr[1:0]};

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        mbox_valid_d = mbox_valid_q;
        resp_valid_d = gnt_any;
        resp_src_d   = resp_src_q;
        resp_we_d    = resp_we_q;
        resp_rdata_d = resp_rdata_q;
        if (gnt_any) begin
            rr_ptr_d     = gnt_src;
            resp_src_d   = gnt_src;
            resp_we_d    = sel_we;
            resp_rdata_d = mbox_q[sel_idx];
            if (sel_we && gnt_src != LOC_SRC) begin
                mbox_valid_d[sel_idx] = 1'b1;
            end else if (!sel_we && gnt_src == LOC_SRC) begin
                mbox_valid_d[sel_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            rr_ptr_q     <= LOC_SRC;
            mbox_valid_q <= '0;
            resp_valid_q <= 1'b0;
            resp_src_q   <= '0;
            resp_we_q    <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            mbox_valid_q <= mbox_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_src_q   <= resp_src_d;
            resp_we_q    <= resp_we_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the mailbox is plain flops and must read back zero after reset, so it is reset too.
            for (int w = 0; w < MBOX_WORDS; w++) begin
                mbox_q[w] <= '0;
            end
        end else if (gnt_any && sel_we) begin
            for (int j = 0; j < 4; j++) begin
                if (sel_be[j]) begin
                    mbox_q[sel_idx][8*j +: 8] <= sel_wdata[8*j +: 8];
                end
            end
        end
    end

    // Write responses and idle lanes always carry zero data.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rmt_rvalid_o[k]          = resp_valid_q && (resp_src_q == 3'(k));
            rmt_rdata_o[32*k +: 32]  = (rmt_rvalid_o[k] && !resp_we_q) ? resp_rdata_q : 32'h0;
        end
        loc_rvalid_o = resp_valid_q && (resp_src_q == LOC_SRC);
        loc_rdata_o  = (loc_rvalid_o && !resp_we_q) ? resp_rdata_q : 32'h0;
    end

    assign mbox_valid_o = mbox_valid_q;
    assign mbox_irq_o   = |mbox_valid_q;

endmodule

// File: tb/tb_ipr_responder.sv
// Scoreboard bench for ipr_responder: directed scenarios plus randomized traffic
// checked against a behavioural mailbox/arbiter model.
module tb_ipr_responder;

    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    rmt_req_i, rmt_we_i;
    logic [127:0]  rmt_addr_i, rmt_wdata_i;
    logic [15:0]   rmt_be_i;
    logic [3:0]    rmt_gnt_o, rmt_rvalid_o;
    logic [127:0]  rmt_rdata_o;
    logic          loc_req_i, loc_we_i;
    logic [31:0]   loc_addr_i, loc_wdata_i;
    logic [3:0]    loc_be_i;
    logic          loc_gnt_o, loc_rvalid_o;
    logic [31:0]   loc_rdata_o;
    logic [MW-1:0] mbox_valid_o;
    logic          mbox_irq_o;

    ipr_responder #(.MBOX_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rmt_req_i(rmt_req_i), .rmt_we_i(rmt_we_i), .rmt_addr_i(rmt_addr_i),
        .rmt_wdata_i(rmt_wdata_i), .rmt_be_i(rmt_be_i), .rmt_gnt_o(rmt_gnt_o),
        .rmt_rvalid_o(rmt_rvalid_o), .rmt_rdata_o(rmt_rdata_o),
        .loc_req_i(loc_req_i), .loc_we_i(loc_we_i), .loc_addr_i(loc_addr_i),
        .loc_wdata_i(loc_wdata_i), .loc_be_i(loc_be_i), .loc_gnt_o(loc_gnt_o),
        .loc_rvalid_o(loc_rvalid_o), .loc_rdata_o(loc_rdata_o),
        .mbox_valid_o(mbox_valid_o), .mbox_irq_o(mbox_irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_loc_rdata = '0;

    // Reference model state
    logic [31:0]   m_mem [MW];
    logic [MW-1:0] m_valid;
    int            m_ptr;

    // Outstanding requests per source (0..3 remote, 4 local)
    bit            p_act   [5];
    logic          p_we    [5];
    logic [31:0]   p_addr  [5];
    logic [31:0]   p_wdata [5];
    logic [3:0]    p_be    [5];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < MW; w++) m_mem[w] = '0;
        m_valid = '0;
        m_ptr   = 4;
        for (int s = 0; s < 5; s++) p_act[s] = 0;
        exp_q.delete();
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < 4; k++) begin
            rmt_req_i[k]            = p_act[k];
            rmt_we_i[k]             = p_we[k];
            rmt_addr_i[32*k +: 32]  = p_addr[k];
            rmt_wdata_i[32*k +: 32] = p_wdata[k];
            rmt_be_i[4*k +: 4]      = p_be[k];
        end
        loc_req_i   = p_act[4];
        loc_we_i    = p_we[4];
        loc_addr_i  = p_addr[4];
        loc_wdata_i = p_wdata[4];
        loc_be_i    = p_be[4];
    endtask

    task automatic issue(input int s, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        p_act[s] = 1; p_we[s] = we; p_addr[s] = addr; p_wdata[s] = wdata; p_be[s] = be;
    endtask

    // Negedge sampling: check flags and grant, then advance the model by one grant.
    task automatic sample(output int act_g);
        int          w;
        int          idx;
        logic [4:0]  exp_g;
        logic [4:0]  got_g;
        resp_t       r;
        drive_inputs();
        @(negedge clk);
        check("mbox_valid", 160'(mbox_valid_o), 160'(m_valid));
        check("mbox_irq", 160'(mbox_irq_o), 160'(m_valid != '0));
        w = -1;
        for (int j = 1; j <= 5; j++) begin
            if (w < 0 && p_act[(m_ptr + j) % 5]) w = (m_ptr + j) % 5;
        end
        exp_g = (w >= 0) ? 5'(1 << w) : 5'b0;
        got_g = {loc_gnt_o, rmt_gnt_o};
        check("grant", 160'(got_g), 160'(exp_g));
        act_g = -1;
        for (int s = 0; s < 5; s++) if (got_g == 5'(1 << s)) act_g = s;
        if (w >= 0) begin
            idx    = int'(p_addr[w] >> 2) % MW;
            r.src  = w;
            r.due  = cyc + 1;
            r.data = p_we[w] ? 32'h0 : m_mem[idx];
            exp_q.push_back(r);
            if (p_we[w]) begin
                for (int b = 0; b < 4; b++)
                    if (p_be[w][b]) m_mem[idx][8*b +: 8] = p_wdata[w][8*b +: 8];
                if (w < 4) m_valid[idx] = 1'b1;
            end else if (w == 4) begin
                m_valid[idx] = 1'b0;
            end
            m_ptr    = w;
            p_act[w] = 0;
        end
    endtask

    task automatic step(output int act_g);
        sample(act_g);
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle();
        int  g;
        int  n;
        bit  busy;
        n = 0;
        busy = 1;
        while (busy && n < 30) begin
            busy = 0;
            for (int s = 0; s < 5; s++) if (p_act[s]) busy = 1;
            if (busy) begin
                step(g);
                n++;
            end
        end
        if (busy) begin
            bad++; total++;
            $display("FAIL drain_timeout: requests still pending after %0d cycles", n);
        end
        step(g);
    endtask

    // Monitor: compares every response lane each cycle against the scoreboard queue.
    initial begin
        resp_t       e;
        logic [4:0]  exp_v;
        logic [159:0] exp_d;
        forever begin
            @(negedge clk);
            exp_v = '0;
            exp_d = '0;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                bad++; total++;
                $display("FAIL resp_missing: src %0d due %0d not seen", e.src, e.due);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                exp_v[e.src]          = 1'b1;
                exp_d[32*e.src +: 32] = e.data;
            end
            check("rvalid", 160'({loc_rvalid_o, rmt_rvalid_o}), 160'(exp_v));
            check("rdata", {loc_rdata_o, rmt_rdata_o}, exp_d);
            if (loc_rvalid_o) last_loc_rdata = loc_rdata_o;
        end
    end

    initial begin
        int g;
        int got [6];
        int exp_order [6];
        exp_order = '{0, 1, 2, 3, 4, 0};
        for (int s = 0; s < 5; s++) begin
            p_we[s] = 0; p_addr[s] = '0; p_wdata[s] = '0; p_be[s] = '0;
        end
        model_reset();
        rst_n = 1'b0;
        drive_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 160'({loc_gnt_o, rmt_gnt_o}), 160'(0));
        check("rst_rvalid", 160'({loc_rvalid_o, rmt_rvalid_o}), 160'(0));
        check("rst_rdata", {loc_rdata_o, rmt_rdata_o}, 160'(0));
        check("rst_mbox", 160'({mbox_irq_o, mbox_valid_o}), 160'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Local read of address 0 after reset returns zero
        issue(4, 0, 32'h0, 32'h0, 4'h0);
        run_until_idle();

        // Fairness: all sources request from rr_ptr=4
        for (int s = 0; s < 5; s++) issue(s, 0, 32'(s * 4), 32'h0, 4'hF);
        for (int n = 0; n < 6; n++) begin
            step(g);
            got[n] = g;
            if (n == 0) issue(0, 0, 32'h20, 32'h0, 4'hF);
        end
        for (int n = 0; n < 6; n++) check("rr_order", 160'(got[n]), 160'(exp_order[n]));
        run_until_idle();

        // Remote E write raises flag 5; local read returns data and clears it
        issue(2, 1, 32'h1900_0014, 32'hDEAD_BEEF, 4'hF);
        run_until_idle();
        check("flag5_set", 160'(mbox_valid_o[5]), 160'(1));
        check("irq_set", 160'(mbox_irq_o), 160'(1));
        issue(4, 0, 32'h14, 32'h0, 4'h0);
        run_until_idle();
        check("read_beef", 160'(last_loc_rdata), 160'(32'hDEAD_BEEF));
        check("irq_clr", 160'(mbox_irq_o), 160'(0));

        // Byte merge on word 3
        issue(4, 1, 32'hC, 32'h1122_3344, 4'hF);
        run_until_idle();
        issue(0, 1, 32'hC, 32'hAABB_CCDD, 4'b0101);
        run_until_idle();
        issue(4, 0, 32'hC, 32'h0, 4'h0);
        run_until_idle();
        check("byte_merge", 160'(last_loc_rdata), 160'(32'h11BB_33DD));

        // Address wrap: 0x40 aliases word 0
        issue(3, 1, 32'h0000_0040, 32'h5A5A_5A5A, 4'hF);
        run_until_idle();
        issue(4, 0, 32'h0, 32'h0, 4'h0);
        run_until_idle();
        check("wrap", 160'(last_loc_rdata), 160'(32'h5A5A_5A5A));

        // Zero byte-enable remote write: data unchanged, flag still set
        issue(1, 1, 32'h24, 32'hFFFF_FFFF, 4'h0);
        run_until_idle();
        check("be0_flag", 160'(mbox_valid_o[9]), 160'(1));

        // Randomized traffic with back-to-back contention
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < 5; s++) begin
                if (!p_act[s] && $urandom_range(99) < 35) begin
                    issue(s, 1'($urandom_range(1)),
                          ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(MW * 4 - 1)),
                          $urandom, 4'($urandom_range(15)));
                end
            end
            step(g);
        end
        run_until_idle();

        // Make sure some flag is set, then reset in the cycle a remote S read is granted
        issue(0, 1, 32'h8, 32'h1234_5678, 4'hF);
        run_until_idle();
        issue(1, 0, 32'h8, 32'h0, 4'h0);
        sample(g);
        check("s_gnt", 160'(g), 160'(1));
        #1 rst_n = 1'b0;
        model_reset();
        drive_inputs();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("rst_no_rvalid", 160'(rmt_rvalid_o), 160'(0));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_flags", 160'({mbox_irq_o, mbox_valid_o}), 160'(0));
        issue(4, 0, 32'h8, 32'h0, 4'h0);
        run_until_idle();
        check("rst_mem_w2", 160'(last_loc_rdata), 160'(0));
        issue(4, 0, 32'hC, 32'h0, 4'h0);
        run_until_idle();
        check("rst_mem_w3", 160'(last_loc_rdata), 160'(0));
        for (int n = 0; n < 3; n++) step(g);
        check("queue_empty", 160'(exp_q.size()), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
